imem_aligner: RTL and testbench
===============================

Name: imem_aligner

Overview:
- Instruction-side memory front end that sits directly upstream of the fetch stage.
- Fetch presents a 16-bit-aligned byte address each cycle. One cycle later this block returns the 64-bit window starting at that address, left-aligned, so the instruction length bits are always at cpu_data[63:62].
- The backing memory is 64 bits wide and 8-byte aligned. A two-entry word buffer (even/odd word slots) supplies windows that straddle word boundaries and refills on miss via a req/ack handshake.

Parameters:
- ADDR_W, 64, width of cpu_addr and mem_addr. Must be at least 4.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- cpu_addr  input  ADDR_W  fetch PC, byte address; bit 0 ignored (treated as 0)
- cpu_addr_valid  input  1  cpu_addr is meaningful this cycle
- cpu_data  output  64  window for the address sampled at the previous edge
- cpu_data_valid  output  1  cpu_data valid this cycle
- flush  input  1  invalidate both buffer entries
- mem_addr  output  ADDR_W  word address, bits [2:0] always 0
- mem_req  output  1  read request, held with stable mem_addr until ack
- mem_ack  input  1  single-cycle response strobe
- mem_rdata  input  64  read data, valid with mem_ack

Behaviour:
- Reset (async):
  - cpu_data=0, cpu_data_valid=0, mem_req=0, mem_addr=0.
  - Both entries invalid; FSM=IDLE; drop flag clear.
- Memory layout: big-endian. The byte at address 8k+j is word k bits [63-8j:56-8j].
- Address decode for a sampled address A:
  - W0 = A[ADDR_W-1:3]; W1 = W0+1, wrapping modulo 2^(ADDR_W-3).
  - Halfword offset o = A[2:1].
  - Window = top 64 bits of ({data(W0),data(W1)} << 16*o).
  - If o==0, only W0 is needed.
- Buffer:
  - Entry e = W[0], so W0 and W1 never conflict.
  - Each entry holds a valid bit, tag W[ADDR_W-4:0] and 64-bit data.
  - A fill always overwrites entry W[0].
- Lookup, every edge with cpu_addr_valid=1 and flush=0:
  - Hit means every needed word is valid with matching tag. The lookup sees a response accepted on the same edge (bypass).
  - Hit: cpu_data <= window; cpu_data_valid <= 1.
  - Miss: cpu_data_valid <= 0, cpu_data holds its value. If FSM=IDLE, the first missing word is registered as the fill target (W0 before W1).
- Lookup with cpu_addr_valid=0: cpu_data_valid <= 0, and no fill is started.
- FSM states:
  - IDLE: mem_req=0. On a miss, go to REQ with mem_addr <= {Wmiss,3'b000}; mem_req is high from the next cycle.
  - REQ: mem_req=1 and mem_addr stable. On mem_ack:
    - Write mem_rdata to the entry (unless the drop flag is set).
    - Go to IDLE.
    - If the same edge's lookup still misses, go straight back to REQ for the next missing word (no idle bubble).
  - A mem_ack while in IDLE is ignored.
- Miss latency with zero-wait memory (ack in the first req cycle):
  - One-word miss at edge N gives valid at edge N+2.
  - Two-word miss gives valid at edge N+3.
  - Add wait cycles per word.
- Address change during a fill (jump or stall release): the in-flight request always completes and its data is written. The lookup then re-evaluates against the current cpu_addr; stale data is never presented.
- flush:
  - Clears both valid bits and forces cpu_data_valid <= 0 on that edge.
  - If in REQ, the drop flag is set; the response is discarded and the flag clears on that ack.
  - flush together with mem_ack: the data is discarded.
- Throughput: back-to-back hits produce one valid window per cycle.
- Outputs depend only on registers; there is no combinational path from cpu_addr to cpu_data_valid, because fetch feeds valid back into its PC.

Test Plan:
- Reset: assert rst_n=0 mid-REQ -> mem_req=0, cpu_data=0 and cpu_data_valid=0 immediately. After release, a lookup of 0x100 misses, showing the entries were invalidated.
- Aligned cold miss:
  - Stimulus: cpu_addr=0x100 held; memory acks the first req cycle with 0x8123_4567_89AB_CDEF.
  - Response: mem_req in cycle 1 with mem_addr=0x100; cpu_data_valid=1 in cycle 2 with cpu_data=0x8123_4567_89AB_CDEF.
- Unaligned straddle:
  - Stimulus: cpu_addr=0x106; word 0x100=0x1111_2222_3333_4444, word 0x108=0x5555_6666_7777_8888.
  - Response: requests to 0x100 then 0x108 back-to-back; cpu_data=0x4444_5555_6666_7777.
- Hit streaming: after the fill above, cpu_addr 0x102, 0x104, 0x108 on consecutive cycles -> valid every cycle, no mem_req, windows correctly shifted.
- Jump mid-fill: miss at 0x200, cpu_addr changes to 0x300 before ack -> 0x200 is still written into entry 0; then a request to 0x300 follows; cpu_data_valid stays 0 until the 0x300 data returns.
- Flush and wrap:
  - Flush during REQ -> the response is dropped and the same word is re-requested.
  - cpu_addr=0xFFFF_FFFF_FFFF_FFFE -> requests 0xFFFF_FFFF_FFFF_FFF8 then 0x0.

Source files
------------

// File: rtl/imem_aligner.sv
// Instruction memory front end: returns the left-aligned 64-bit window at a
// halfword-aligned fetch address, backed by a two-word buffer refilled over req/ack.
module imem_aligner #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_addr_valid,
    output logic [63:0]       cpu_data,
    output logic              cpu_data_valid,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata
);

    localparam int WW = ADDR_W - 3;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_drop;
    logic            w_drop_nxt;
    logic [WW-1:0]   r_fill_w;
    logic [WW-1:0]   w_fill_nxt;

    logic [1:0]      r_valid;
    logic [WW-1:0]   r_tag  [2];
    logic [63:0]     r_data [2];

    logic [WW-1:0]   w_w0;
    logic [WW-1:0]   w_w1;
    logic [1:0]      w_off;
    logic            w_accept;
    logic            w_fill_e;
    logic [1:0]      w_ev;
    logic [WW-1:0]   w_et [2];
    logic [63:0]     w_ed [2];
    logic            w_hit0;
    logic            w_hit1;
    logic            w_lookup;
    logic            w_hit;
    logic            w_miss;
    logic [WW-1:0]   w_miss_w;
    logic [127:0]    w_pair;
    logic [127:0]    w_shifted;
    logic [63:0]     w_window;
    logic [64:0]     w_unused;

    assign w_w0     = cpu_addr[ADDR_W-1:3];
    assign w_w1     = w_w0 + {{(WW-1){1'b0}}, 1'b1};
    assign w_off    = cpu_addr[2:1];
    assign w_fill_e = r_fill_w[0];
    // A response accepted this edge is visible to the same edge's lookup.
    assign w_accept = (r_state == REQ) && mem_ack && !r_drop && !flush;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        for (int e = 0; e < 2; e++) begin
            w_ev[e] = r_valid[e];
            w_et[e] = r_tag[e];
            w_ed[e] = r_data[e];
            if (w_accept && (w_fill_e == 1'(e))) begin
                w_ev[e] = 1'b1;
                w_et[e] = r_fill_w;
                w_ed[e] = mem_rdata;
            end
        end
    end

    assign w_hit0    = w_ev[w_w0[0]] && (w_et[w_w0[0]] == w_w0);
    assign w_hit1    = (w_off == 2'd0) || (w_ev[w_w1[0]] && (w_et[w_w1[0]] == w_w1));
    assign w_lookup  = cpu_addr_valid && !flush;
    assign w_hit     = w_lookup && w_hit0 && w_hit1;
    assign w_miss    = w_lookup && !(w_hit0 && w_hit1);
    assign w_miss_w  = w_hit0 ? w_w1 : w_w0;

    assign w_pair    = {w_ed[w_w0[0]], w_ed[w_w1[0]]};
    assign w_shifted = w_pair << {w_off, 4'b0000};
    assign w_window  = w_shifted[127:64];
    assign w_unused  = {cpu_addr[0], w_shifted[63:0]};

    assign mem_req  = (r_state == REQ);
    assign mem_addr = {r_fill_w, 3'b000};

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_w;
        w_drop_nxt  = r_drop;
        case (r_state)
            IDLE: begin
                if (w_miss) begin
                    w_state_nxt = REQ;
                    w_fill_nxt  = w_miss_w;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    w_state_nxt = IDLE;
                    w_drop_nxt  = 1'b0;
                    if (w_miss) begin
                        w_state_nxt = REQ;
                        w_fill_nxt  = w_miss_w;
                    end
                end else if (flush) begin
                    w_drop_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_drop   <= 1'b0;
            r_fill_w <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_drop   <= w_drop_nxt;
            r_fill_w <= w_fill_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid        <= 2'b00;
            cpu_data       <= '0;
            cpu_data_valid <= 1'b0;
        end else begin
            if (flush) begin
                r_valid <= 2'b00;
            end else if (w_accept) begin
                r_valid[w_fill_e] <= 1'b1;
            end
            cpu_data_valid <= w_hit;
            if (w_hit) begin
                cpu_data <= w_window;
            end
        end
    end

    // NOTE: tag/data storage is not reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag[w_fill_e]  <= r_fill_w;
            r_data[w_fill_e] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_imem_aligner.sv
// Directed bench for imem_aligner: memory responder, byte-level window model,
// and a scoreboard of expected windows popped whenever cpu_data_valid is seen.
module tb_imem_aligner;

    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_addr_valid;
    logic [63:0]       cpu_data;
    logic              cpu_data_valid;
    logic              flush;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [63:0]       mem_rdata;

    logic [63:0] mem [logic [63:0]];
    logic [63:0] sb [$];
    logic [63:0] req_log [$];
    logic        ack_en;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat;

    imem_aligner #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_addr       (cpu_addr),
        .cpu_addr_valid (cpu_addr_valid),
        .cpu_data       (cpu_data),
        .cpu_data_valid (cpu_data_valid),
        .flush          (flush),
        .mem_addr       (mem_addr),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    // Big-endian byte walk: window byte i is memory byte (A & ~1) + i.
    function automatic logic [63:0] model(input logic [63:0] a);
        logic [63:0] r;
        logic [63:0] b;
        logic [63:0] w;
        int          j;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            b = {a[63:1], 1'b0} + 64'(i);
            w = mem_word({b[63:3], 3'b000});
            j = int'(b[2:0]);
            r = {r[55:0], w[63-8*j -: 8]};
        end
        return r;
    endfunction

    // Memory responder: acks in the first request cycle whenever enabled.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && ack_en) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                req_log.push_back(mem_addr);
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [63:0] e;
        @(posedge clk);
        @(negedge clk);
        if (cpu_data_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_valid: observed data %h expected no output", cpu_data);
            end else begin
                e = sb.pop_front();
                check("window", cpu_data, e);
            end
        end
    endtask

    task automatic wait_valid(input int max_cycles, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!cpu_data_valid && cycles < max_cycles);
        cpu_addr_valid = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a, input logic [63:0] exp, input int exp_lat);
        sb.push_back(exp);
        cpu_addr       = a;
        cpu_addr_valid = 1'b1;
        wait_valid(20, lat);
        check("latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic check_log(input string tag, input logic [63:0] a0, input logic [63:0] a1);
        check({tag, "_count"}, 64'(req_log.size()), 64'd2);
        if (req_log.size() >= 2) begin
            check({tag, "_0"}, req_log[0], a0);
            check({tag, "_1"}, req_log[1], a1);
        end
        req_log.delete();
    endtask

    initial begin
        rst_n          = 1'b0;
        cpu_addr       = '0;
        cpu_addr_valid = 1'b0;
        flush          = 1'b0;
        ack_en         = 1'b1;
        #12;
        check("rst_data",  cpu_data, 64'd0);
        check("rst_valid", 64'(cpu_data_valid), 64'd0);
        check("rst_req",   64'(mem_req), 64'd0);
        check("rst_addr",  mem_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Aligned cold miss
        mem[64'h100] = 64'h8123_4567_89AB_CDEF;
        sb.push_back(64'h8123_4567_89AB_CDEF);
        cpu_addr       = 64'h100;
        cpu_addr_valid = 1'b1;
        step();
        check("cold_req",   64'(mem_req), 64'd1);
        check("cold_addr",  mem_addr, 64'h100);
        check("cold_valid1", 64'(cpu_data_valid), 64'd0);
        step();
        check("cold_valid2", 64'(cpu_data_valid), 64'd1);
        cpu_addr_valid = 1'b0;
        step();
        req_log.delete();

        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", 64'(cpu_data_valid), 64'd0);

        // Unaligned straddle, two-word miss
        mem[64'h100] = 64'h1111_2222_3333_4444;
        mem[64'h108] = 64'h5555_6666_7777_8888;
        fetch(64'h106, 64'h4444_5555_6666_7777, 3);
        check_log("straddle_req", 64'h100, 64'h108);

        // Back-to-back hits
        cpu_addr_valid = 1'b1;
        cpu_addr = 64'h102; sb.push_back(64'h2222_3333_4444_5555); step();
        check("stream_req0", 64'(mem_req), 64'd0);
        check("stream_v0", 64'(cpu_data_valid), 64'd1);
        cpu_addr = 64'h104; sb.push_back(64'h3333_4444_5555_6666); step();
        check("stream_req1", 64'(mem_req), 64'd0);
        check("stream_v1", 64'(cpu_data_valid), 64'd1);
        cpu_addr = 64'h108; sb.push_back(64'h5555_6666_7777_8888); step();
        check("stream_req2", 64'(mem_req), 64'd0);
        check("stream_v2", 64'(cpu_data_valid), 64'd1);
        cpu_addr_valid = 1'b0;
        step();
        check("stream_log", 64'(req_log.size()), 64'd0);

        // Jump mid-fill
        ack_en         = 1'b0;
        cpu_addr       = 64'h200;
        cpu_addr_valid = 1'b1;
        step();
        check("jump_addr0", mem_addr, 64'h200);
        cpu_addr = 64'h300;
        sb.push_back(model(64'h300));
        step();
        check("jump_addr1", mem_addr, 64'h200);
        check("jump_valid", 64'(cpu_data_valid), 64'd0);
        ack_en = 1'b1;
        wait_valid(20, lat);
        check("jump_done", 64'(cpu_data_valid), 64'd1);
        check_log("jump_req", 64'h200, 64'h300);

        // Flush during REQ drops the response and re-requests
        ack_en         = 1'b0;
        cpu_addr       = 64'h400;
        cpu_addr_valid = 1'b1;
        step();
        check("flush_req", 64'(mem_req), 64'd1);
        flush = 1'b1;
        step();
        flush  = 1'b0;
        ack_en = 1'b1;
        sb.push_back(model(64'h400));
        wait_valid(20, lat);
        check("flush_done", 64'(cpu_data_valid), 64'd1);
        check_log("flush_rereq", 64'h400, 64'h400);

        // Address wrap at the top of memory
        fetch(64'hFFFF_FFFF_FFFF_FFFE, model(64'hFFFF_FFFF_FFFF_FFFE), 3);
        check_log("wrap_req", 64'hFFFF_FFFF_FFFF_FFF8, 64'h0);

        // Asynchronous reset mid-REQ invalidates the buffer
        fetch(64'h100, model(64'h100), 2);
        req_log.delete();
        ack_en         = 1'b0;
        cpu_addr       = 64'h508;
        cpu_addr_valid = 1'b1;
        step();
        check("mid_req", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_req",   64'(mem_req), 64'd0);
        check("arst_data",  cpu_data, 64'd0);
        check("arst_valid", 64'(cpu_data_valid), 64'd0);
        check("arst_addr",  mem_addr, 64'd0);
        cpu_addr_valid = 1'b0;
        step();
        rst_n  = 1'b1;
        ack_en = 1'b1;
        req_log.delete();
        cpu_addr       = 64'h100;
        cpu_addr_valid = 1'b1;
        sb.push_back(model(64'h100));
        step();
        check("post_rst_miss", 64'(mem_req), 64'd1);
        check("post_rst_addr", mem_addr, 64'h100);
        check("post_rst_v0", 64'(cpu_data_valid), 64'd0);
        step();
        check("post_rst_v1", 64'(cpu_data_valid), 64'd1);
        cpu_addr_valid = 1'b0;
        step();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
